// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU-side memory bus initiator.
// Holds the access-size and FSM-state encodings, plus lane-enable and alignment helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: be_for = 4'b0001 << a;
      SZ_HALF: be_for = 4'b0011 << a;
      default: be_for = 4'b1111;
    endcase
  endfunction

  // The reserved size 2'b11 is reported as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a bus word, and places
// store data into its byte lanes, either alone (masked write) or merged into a read word.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] place_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] wdata_trim;
  logic [3:0]  be;
  logic [31:0] keep_mask;

  assign shamt   = {lane, 3'b000};
  assign shifted = rword >> shamt;
  assign be      = be_for(size, lane);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign keep_mask[8*gi +: 8] = {8{~be[gi]}};
    end
  endgenerate

  always_comb begin
    load_data  = rword;
    wdata_trim = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        wdata_trim = {24'd0, wdata[7:0]};
      end
      SZ_HALF: begin
        load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        wdata_trim = {16'd0, wdata[15:0]};
      end
      default: begin
        load_data  = rword;
        wdata_trim = wdata;
      end
    endcase
  end

  assign place_data = wdata_trim << shamt;
  assign merge_data = (rword & keep_mask) | place_data;

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding load/store initiator for a word-wide memory bus with fixed read latency.
// Partial stores use read-modify-write unless the responder honours byteenable.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int WORD_ADDR      = 1,
  parameter int USE_BYTEENABLE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

  state_e      state_reg;
  logic [1:0]  lane_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  lat_cnt_reg;
  logic [31:0] address_reg;
  logic [3:0]  byteenable_reg;
  logic        read_reg;
  logic        write_reg;
  logic [31:0] writedata_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic        idle;
  logic [1:0]  al_size;
  logic [1:0]  al_lane;
  logic        al_signed;
  logic [31:0] al_wdata;
  logic [31:0] load_data;
  logic [31:0] place_data;
  logic [31:0] merge_data;

  assign idle = (state_reg == ST_IDLE);

  // While idle the aligner sees the live request so a direct write can launch on acceptance.
  assign al_size   = idle ? req_size   : size_reg;
  assign al_lane   = idle ? req_addr[1:0] : lane_reg;
  assign al_signed = idle ? req_signed : signed_reg;
  assign al_wdata  = idle ? req_wdata  : wdata_reg;

  mem_lane_align u_align (
    .size       (al_size),
    .sign_ext   (al_signed),
    .lane       (al_lane),
    .rword      (readdata),
    .wdata      (al_wdata),
    .load_data  (load_data),
    .place_data (place_data),
    .merge_data (merge_data)
  );

  function automatic logic [31:0] bus_addr(input logic [31:0] a);
    if (WORD_ADDR != 0) return {2'b00, a[31:2]};
    return {a[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      lane_reg       <= 2'b00;
      size_reg       <= 2'b00;
      signed_reg     <= 1'b0;
      we_reg         <= 1'b0;
      wdata_reg      <= 32'd0;
      lat_cnt_reg    <= 3'd0;
      address_reg    <= 32'd0;
      byteenable_reg <= 4'd0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      writedata_reg  <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            lane_reg   <= req_addr[1:0];
            size_reg   <= req_size;
            signed_reg <= req_signed;
            we_reg     <= req_we;
            wdata_reg  <= req_wdata;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'd0;
              state_reg      <= ST_RESP;
            end else if (!req_we || (USE_BYTEENABLE == 0 && req_size != SZ_WORD)) begin
              read_reg       <= 1'b1;
              address_reg    <= bus_addr(req_addr);
              byteenable_reg <= 4'b1111;
              state_reg      <= ST_RD_REQ;
            end else begin
              write_reg      <= 1'b1;
              address_reg    <= bus_addr(req_addr);
              byteenable_reg <= (USE_BYTEENABLE != 0) ? be_for(req_size, req_addr[1:0]) : 4'b1111;
              writedata_reg  <= place_data;
              state_reg      <= ST_WR_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (!waitrequest) begin
            read_reg    <= 1'b0;
            lat_cnt_reg <= 3'd1;
            state_reg   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt_reg == LAT_LAST) begin
            if (we_reg) begin
              write_reg      <= 1'b1;
              byteenable_reg <= 4'b1111;
              writedata_reg  <= merge_data;
              state_reg      <= ST_WR_REQ;
            end else begin
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b0;
              resp_rdata_reg <= load_data;
              state_reg      <= ST_RESP;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end
        ST_WR_REQ: begin
          if (!waitrequest) begin
            write_reg      <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
            state_reg      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign address    = address_reg;
  assign byteenable = byteenable_reg;
  assign read       = read_reg;
  assign write      = write_reg;
  assign writedata  = writedata_reg;

endmodule
